// File: rtl/tri_vertex_fetch.sv
// Triangle vertex fetch: takes index triplets, reads three BRAM ports in parallel,
// and streams the assembled triangle downstream. Out-of-range triplets are dropped.
module tri_vertex_fetch #(
  parameter int DATAWIDTH    = 8,
  parameter int DEPTH        = 16,
  parameter int NUM_VERTICES = DEPTH,
  parameter int COUNT_WIDTH  = 16,
  localparam int IW          = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IW-1:0]          in_idx_0,
  input  logic [IW-1:0]          in_idx_1,
  input  logic [IW-1:0]          in_idx_2,
  input  logic                   in_last,
  output logic                   read_en_port_0,
  output logic                   read_en_port_1,
  output logic                   read_en_port_2,
  output logic [IW-1:0]          addr_read_port_0,
  output logic [IW-1:0]          addr_read_port_1,
  output logic [IW-1:0]          addr_read_port_2,
  input  logic [DATAWIDTH-1:0]   read_data_port_0,
  input  logic [DATAWIDTH-1:0]   read_data_port_1,
  input  logic [DATAWIDTH-1:0]   read_data_port_2,
  input  logic                   read_dv_port_0,
  input  logic                   read_dv_port_1,
  input  logic                   read_dv_port_2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATAWIDTH-1:0]   out_vertex_0,
  output logic [DATAWIDTH-1:0]   out_vertex_1,
  output logic [DATAWIDTH-1:0]   out_vertex_2,
  output logic                   out_last,
  output logic                   done,
  output logic                   err_index,
  output logic [COUNT_WIDTH-1:0] tri_count,
  output logic [1:0]             dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
  // A producer holds valid and its payload stable until that edge; ready may toggle freely.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [IW:0] NV_LIM = (IW+1)'(NUM_VERTICES);

  state_t                   state_q, state_d;
  logic [IW-1:0]            addr_q [3];
  logic [IW-1:0]            addr_d [3];
  logic [DATAWIDTH-1:0]     vtx_q  [3];
  logic [DATAWIDTH-1:0]     vtx_d  [3];
  logic [2:0]               got_q, got_d;
  logic                     rd_en_q, rd_en_d;
  logic                     last_q, last_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]            idx_in  [3];
  logic [DATAWIDTH-1:0]     rd_data [3];
  logic                     rd_dv   [3];
  logic                     accept;
  logic                     idx_bad;

  assign idx_in[0]  = in_idx_0;
  assign idx_in[1]  = in_idx_1;
  assign idx_in[2]  = in_idx_2;
  assign rd_data[0] = read_data_port_0;
  assign rd_data[1] = read_data_port_1;
  assign rd_data[2] = read_data_port_2;
  assign rd_dv[0]   = read_dv_port_0;
  assign rd_dv[1]   = read_dv_port_1;
  assign rd_dv[2]   = read_dv_port_2;

  // in_ready is the only combinational output; it is forced low while reset is held.
  assign in_ready = (state_q == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign idx_bad  = ({1'b0, in_idx_0} >= NV_LIM) ||
                    ({1'b0, in_idx_1} >= NV_LIM) ||
                    ({1'b0, in_idx_2} >= NV_LIM);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    vtx_d       = vtx_q;
    got_d       = got_q;
    rd_en_d     = 1'b0;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;

    // The batch count is shown for exactly the done cycle, then cleared.
    if (done_q) begin
      cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (idx_bad) begin
            err_d  = 1'b1;
            done_d = in_last;
          end else begin
            for (int k = 0; k < 3; k++) begin
              addr_d[k] = idx_in[k];
            end
            last_d  = in_last;
            rd_en_d = 1'b1;
            got_d   = 3'b000;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Each port keeps the first word it returns; ports may finish on different cycles.
        for (int k = 0; k < 3; k++) begin
          if (rd_dv[k] && !got_q[k]) begin
            vtx_d[k] = rd_data[k];
            got_d[k] = 1'b1;
          end
        end
        if (&got_d) begin
          out_valid_d = 1'b1;
          out_last_d  = last_q;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          cnt_d       = cnt_q + COUNT_WIDTH'(1);
          done_d      = out_last_q;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int k = 0; k < 3; k++) begin
        addr_q[k] <= '0;
        vtx_q[k]  <= '0;
      end
      got_q       <= 3'b000;
      rd_en_q     <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      for (int k = 0; k < 3; k++) begin
        addr_q[k] <= addr_d[k];
        vtx_q[k]  <= vtx_d[k];
      end
      got_q       <= got_d;
      rd_en_q     <= rd_en_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign read_en_port_0   = rd_en_q;
  assign read_en_port_1   = rd_en_q;
  assign read_en_port_2   = rd_en_q;
  assign addr_read_port_0 = addr_q[0];
  assign addr_read_port_1 = addr_q[1];
  assign addr_read_port_2 = addr_q[2];
  assign out_valid        = out_valid_q;
  assign out_vertex_0     = vtx_q[0];
  assign out_vertex_1     = vtx_q[1];
  assign out_vertex_2     = vtx_q[2];
  assign out_last         = out_last_q;
  assign done             = done_q;
  assign err_index        = err_q;
  assign tri_count        = cnt_q;
  assign dbg_state        = state_q;

endmodule
